unpermute: RTL and testbench

// - Inverse of the HPU hypervector permute unit: rotates a DIM+1-bit hypervector LEFT by permute_num.

---
 rtl/hpu_pkg.sv | 20 ++
 rtl/unpermute_if.sv | 15 +
 rtl/unpermute_stage.sv | 35 +++
 rtl/unpermute.sv | 119 +++++++++++
 tb/tb_unpermute.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/hpu_pkg.sv
// Shared HPU hypervector types and constants.
//   DIM        MSB index of a hypervector (width DIM+1 = 1024)
//   NUM_W      width of a rotate amount, $clog2(DIM+1)
//   ROT_STAGES number of barrel stages (one per bit pair of the amount)
//   rotl()     reference rotate-left, used by models outside the datapath
package hpu_pkg;
  localparam int DIM        = 1023;
  localparam int NUM_W      = $clog2(DIM + 1);
  localparam int ROT_STAGES = 5;

  typedef logic [DIM:0]       hv_t;
  typedef logic [NUM_W-1:0]   permute_num_t;

  function automatic hv_t rotl(hv_t x, int r);
    int rr;
    rr = r % (DIM + 1);
    if (rr == 0) return x;
    return (x << rr) | (x >> (DIM + 1 - rr));
  endfunction
endpackage

// File: rtl/unpermute_if.sv
// Valid/ready hypervector stream carrying a rotate amount as a tag.
//   valid/ready  handshake, transfer on valid && ready
//   data         hypervector
//   num          rotate amount k travelling with the vector
// master drives valid/data/num, slave drives ready.
interface unpermute_if;
  import hpu_pkg::*;
  logic         valid;
  logic         ready;
  hv_t          data;
  permute_num_t num;

  modport master (output valid, data, num, input ready);
  modport slave  (input valid, data, num, output ready);
endinterface

// File: rtl/unpermute_stage.sv
// One combinational barrel stage of the unpermute rotator.
//   din  vector in        lo  amount bit k[STAGE]
//   dout vector out       hi  amount bit k[NUM_W-1-STAGE]
// Pairing a low and a high amount bit per stage gives five stages for a
// 10-bit amount; the stage rotates left by 0, 2^STAGE, 2^(9-STAGE) or both.
module unpermute_stage
  import hpu_pkg::*;
#(
  parameter int STAGE = 0
) (
  input  hv_t  din,
  input  logic lo,
  input  logic hi,
  output hv_t  dout
);
  localparam int LO   = 1 << STAGE;
  localparam int HI   = 1 << (NUM_W - 1 - STAGE);
  localparam int BOTH = LO + HI;

  hv_t r_lo, r_hi, r_both;

  assign r_lo   = {din[DIM-LO:0],   din[DIM:DIM-LO+1]};
  assign r_hi   = {din[DIM-HI:0],   din[DIM:DIM-HI+1]};
  assign r_both = {din[DIM-BOTH:0], din[DIM:DIM-BOTH+1]};

  always_comb begin
    dout = din;
    case ({hi, lo})
      2'b01:   dout = r_lo;
      2'b10:   dout = r_hi;
      2'b11:   dout = r_both;
      default: dout = din;
    endcase
  end
endmodule

// File: rtl/unpermute.sv
// Inverse hypervector permute: out_data = rotate-left(in_data, in_num).
//   clk, rst   clock, synchronous active-high reset
//   in_s       slave stream: permuted vector + amount k
//   out_s      master stream: recovered vector + k carried as a tag
// Build option UNPERMUTE_PIPE_EN:
//   defined   - each of the 5 stages registered with its own valid, 5-cycle
//               latency, skid-free ready chain so a full pipe runs at 1/cycle.
//   undefined - 5 combinational stages feeding one output register, 1-cycle
//               latency, 1/cycle.
module unpermute
  import hpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  unpermute_if.slave  in_s,
  unpermute_if.master out_s
);
  localparam int LAST = ROT_STAGES - 1;

`ifdef UNPERMUTE_PIPE_EN
  // vld_pipe[0] is the input valid, vld_pipe[s+1] the valid of stage s's register.
  logic [ROT_STAGES:0]   vld_pipe;
  logic [ROT_STAGES-1:0] stage_ready;

  assign vld_pipe[0] = in_s.valid;

  // Stage s can load if any register from s to the output is empty or the
  // consumer takes the output this cycle; accumulated without self-reference.
  always_comb begin
    logic r;
    r           = out_s.ready;
    stage_ready = '0;
    for (int s = LAST; s >= 0; s--) begin
      r              = r || !vld_pipe[s+1];
      stage_ready[s] = r;
    end
  end
`endif

  for (genvar s = 0; s < ROT_STAGES; s++) begin : g_stage
    hv_t          din;
    hv_t          dout;
    permute_num_t num;

`ifdef UNPERMUTE_PIPE_EN
    hv_t          data_q;
    permute_num_t num_q;
    logic         vld_q;

    if (s == 0) begin : g_head
      assign din = in_s.data;
      assign num = in_s.num;
    end else begin : g_body
      assign din = g_stage[s-1].data_q;
      assign num = g_stage[s-1].num_q;
    end

    assign vld_pipe[s+1] = vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        num_q  <= '0;
      end else if (stage_ready[s]) begin
        vld_q <= vld_pipe[s];
        if (vld_pipe[s]) begin
          data_q <= dout;
          num_q  <= num;
        end
      end
    end
`else
    assign num = in_s.num;
    if (s == 0) begin : g_head
      assign din = in_s.data;
    end else begin : g_body
      assign din = g_stage[s-1].dout;
    end
`endif

    unpermute_stage #(.STAGE(s)) u_stage (
      .din  (din),
      .lo   (num[s]),
      .hi   (num[NUM_W-1-s]),
      .dout (dout)
    );
  end

`ifdef UNPERMUTE_PIPE_EN
  assign in_s.ready = stage_ready[0];
  assign out_s.valid = vld_pipe[ROT_STAGES];
  assign out_s.data  = g_stage[LAST].data_q;
  assign out_s.num   = g_stage[LAST].num_q;
`else
  hv_t          data_q;
  permute_num_t num_q;
  logic         vld_q;

  assign in_s.ready  = !vld_q || out_s.ready;
  assign out_s.valid = vld_q;
  assign out_s.data  = data_q;
  assign out_s.num   = num_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      num_q  <= '0;
    end else if (in_s.ready) begin
      vld_q <= in_s.valid;
      if (in_s.valid) begin
        data_q <= g_stage[LAST].dout;
        num_q  <= in_s.num;
      end
    end
  end
`endif
endmodule

// File: tb/tb_unpermute.sv
// Self-checking bench for unpermute (either UNPERMUTE_PIPE_EN setting).
// Expected outputs come from an index-formula model of the inverse rotate
// (out[i] = in[(i-k) mod 1024]) or from directed constants, queued in
// acceptance order and compared as the DUT emits them.
module tb_unpermute;
  import hpu_pkg::*;

`ifdef UNPERMUTE_PIPE_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    hv_t          d;
    permute_num_t n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  unpermute_if in_if ();
  unpermute_if out_if ();

  unpermute dut (
    .clk   (clk),
    .rst   (rst),
    .in_s  (in_if),
    .out_s (out_if)
  );

  always #5 clk = ~clk;

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, n_out = 0, n_acc = 0, first_out = 0, last_out = 0;
  exp_t q[$];
  hv_t  nxt_exp;
  logic rand_rdy = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (low 128b) t=%0t", tag, got[127:0], exp[127:0], $time);
    end
  endtask

  function automatic hv_t model(hv_t x, int k);
    hv_t r;
    for (int i = 0; i <= DIM; i++) r[i] = x[(i - k + DIM + 1) % (DIM + 1)];
    return r;
  endfunction

  function automatic hv_t rand_hv();
    hv_t v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Scoreboard: values seen at negedge are those the next posedge acts on.
  always @(negedge clk) begin
    exp_t e;
    if (rst) q.delete();
    else begin
      if (out_if.valid && out_if.ready) begin
        if (q.size() == 0) chk("spurious_out", out_if.valid, 1'b0);
        else begin
          e = q.pop_front();
          chk("data", out_if.data, e.d);
          chk("num", out_if.num, e.n);
          n_out++;
          if (n_out == 1) first_out = cyc;
          last_out = cyc;
        end
      end
      if (in_if.valid && in_if.ready) begin
        q.push_back('{nxt_exp, in_if.num});
        n_acc++;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_if.ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input hv_t d, input permute_num_t k, input hv_t e);
    int w = 0;
    in_if.valid = 1'b1;
    in_if.data  = d;
    in_if.num   = k;
    nxt_exp     = e;
    @(negedge clk);
    while (!(in_if.ready && !rst) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) chk("accept_timeout", in_if.ready, 1'b1);
    @(posedge clk); #1;
    in_if.valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    hv_t x, one;
    int  ks[9] = '{0, 1, 512, 513, 258, 132, 72, 48, 1023};
    int  start, nb;
    one = 1;

    rst = 1'b1;
    in_if.valid = 1'b0; in_if.data = '0; in_if.num = '0;
    out_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_if.valid, 1'b0);
    chk("rst_out_data", out_if.data, '0);
    chk("rst_out_num", out_if.num, '0);
    chk("rst_in_ready", in_if.ready, 1'b1);

    // Round trip: permute is a right rotation by k.
    foreach (ks[i]) begin
      x = rand_hv();
      send(rotl(x, (DIM + 1 - ks[i]) % (DIM + 1)), permute_num_t'(ks[i]), x);
    end
    send(one, 10'd5, one << 5);
    send(one << 1023, 10'd1, one);
    drain();

    // Throughput / latency at full rate.
    n_out = 0;
    start = cyc;
    for (int i = 0; i < 100; i++) begin
      x = rand_hv();
      send(x, permute_num_t'($urandom_range(0, DIM)), '0);
      q[q.size()-1].d = model(x, int'(in_if.num));
    end
    drain();
    chk("tp_count", n_out, 100);
    chk("tp_latency", first_out - start, LAT);
    chk("tp_no_bubble", last_out - first_out, 99);

    // Backpressure: hold out_ready low, pipe fills, head output stays put.
    out_if.ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          hv_t d;
          permute_num_t k;
          d = rand_hv();
          k = permute_num_t'($urandom_range(0, DIM));
          send(d, k, model(d, int'(k)));
        end
      end
      begin
        hv_t  held;
        logic seen;
        seen = 1'b0;
        repeat (12) begin
          @(negedge clk);
          if (out_if.valid) begin
            if (!seen) begin held = out_if.data; seen = 1'b1; end
            else chk("bp_stable", out_if.data, held);
          end
        end
        chk("bp_accepted", n_acc, LAT);
        chk("bp_in_ready_low", in_if.ready, 1'b0);
        @(posedge clk); #1;
        out_if.ready = 1'b1;
      end
    join
    drain();

    // Reset with vectors in flight: none of them may emerge.
    for (int i = 0; i < 3; i++) begin
      x = rand_hv();
      send(x, permute_num_t'($urandom_range(0, DIM)), '0);
      q[q.size()-1].d = model(x, int'(in_if.num));
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", out_if.valid, 1'b0);
    chk("mid_rst_in_ready", in_if.ready, 1'b1);
    rst = 1'b0;
    nb = n_out;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_none_emerge", n_out - nb, 0);

    // Random traffic.
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      hv_t d;
      permute_num_t k;
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      d = rand_hv();
      k = permute_num_t'($urandom_range(0, DIM));
      send(d, k, model(d, int'(k)));
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    out_if.ready = 1'b1;
    drain();
    chk("final_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
